// File: rtl/alu_seq.sv
// alu_seq: runs a multi-byte AND/XOR/LSH/RSH through the 8-bit ALU, one byte per cycle.
// Define ALU_SEQ_STALL_EN to add a stall input that freezes progress while in RUN.
module alu_seq #(
  parameter int ADDR_W = 8,
  parameter int MAXLEN = 4,
  parameter int LEN_W  = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] d_base,
  input  logic              sc_init,
`ifdef ALU_SEQ_STALL_EN
  input  logic              stall,
`endif
  output logic [ADDR_W-1:0] rd_a_addr,
  input  logic [7:0]        rd_a_data,
  output logic [ADDR_W-1:0] rd_b_addr,
  input  logic [7:0]        rd_b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_sc_in,
  input  logic [7:0]        alu_out,
  input  logic              alu_sc_out,
  input  logic              alu_beven,
  output logic              busy,
  output logic              done,
  output logic              carry_out,
  output logic              zero_all,
  output logic              odd_all
);

  localparam logic [2:0] kNOP = 3'b000;
  localparam logic [2:0] kRSH = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  a_q, b_q, d_q;
  logic [LEN_W-1:0]   i_q;
  logic               carry_q, zero_q, odd_q;

  logic [LEN_W-1:0]   len_clamp;
  logic [LEN_W-1:0]   k;
  logic               accept, advance, last;

  assign len_clamp = (len > LEN_W'(MAXLEN)) ? LEN_W'(MAXLEN) : len;
  assign accept    = (state_q == S_IDLE) && start;
`ifdef ALU_SEQ_STALL_EN
  assign advance   = (state_q == S_RUN) && !stall;
`else
  assign advance   = (state_q == S_RUN);
`endif
  assign last      = (i_q == len_q - LEN_W'(1));
  // RSH walks the word MSB first so the shifted-in bit flows downward
  assign k         = (op_q == kRSH) ? (len_q - LEN_W'(1) - i_q) : i_q;

  // Control state: reset applies here only
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        i_q     <= '0;
        carry_q <= sc_init;
        zero_q  <= 1'b1;
        odd_q   <= 1'b0;
      end else if (advance) begin
        i_q     <= i_q + LEN_W'(1);
        carry_q <= alu_sc_out;
        zero_q  <= zero_q & (alu_out == 8'h00);
        odd_q   <= odd_q ^ alu_beven;
      end
    end
  end

  // Command capture: data only, no reset needed
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_q  <= op;
      len_q <= len_clamp;
      a_q   <= a_base;
      b_q   <= b_base;
      d_q   <= d_base;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (len_clamp == '0) ? S_DONE : S_RUN;
      S_RUN:  if (advance && last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_a_addr = '0;
    rd_b_addr = '0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_en     = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = kNOP;
    alu_sc_in = 1'b0;
    if (state_q == S_RUN) begin
      rd_a_addr = a_q + ADDR_W'(k);
      rd_b_addr = b_q + ADDR_W'(k);
      wr_addr   = d_q + ADDR_W'(k);
      wr_data   = alu_out;
      // Gate with Reset so no byte is written on the edge that aborts a run
      wr_en     = advance && !Reset;
      alu_a     = rd_a_data;
      alu_b     = rd_b_data;
      alu_op    = op_q;
      alu_sc_in = carry_q;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign carry_out = carry_q;
  assign zero_all  = zero_q;
  assign odd_all   = odd_q;

endmodule
